// File: rtl/flash_phy_pkg.sv
// Shared definitions for the flash physical-side sequencers (erase, program, read).
// Holds the sequencer state encodings, the erase op encodings and small
// elaboration-time helpers used to size counters.
package flash_phy_pkg;

  // Sequencer state encodings. These are kept as plain constants so that legacy
  // blocks comparing against raw 2-bit codes keep working.
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StErase = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
  localparam logic [1:0] StErr   = 2'd3;

  // Erase op encodings as seen on op_i.
  localparam logic PageErase = 1'b0;
  localparam logic BankErase = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of a down counter that must hold (cycles - 1) for the longer of the
  // two erase durations. Never narrower than one bit so a 1-cycle erase still
  // gets a real register.
  function automatic int erase_cnt_width(input int page_cycles, input int bank_cycles);
    int w;
    w = $clog2(max_int(page_cycles, bank_cycles));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/flash_phy_erase_timer.sv
// Loadable down counter with a zero flag, used to time how long the macro
// erase strobe is held.
//
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous active-low reset (counter clears to 0)
//   load_i   in   load value_i into the counter (has priority over en_i)
//   value_i  in   CntW  value to load
//   en_i     in   decrement by one; the counter saturates at 0 and never wraps
//   zero_o   out  counter currently equals 0
module flash_phy_erase_timer #(
  parameter int CntW = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] value_i,
  input  logic            en_i,
  output logic            zero_o
);

  logic [CntW-1:0] count_reg;

  assign zero_o = (count_reg == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg <= '0;
    end else if (load_i) begin
      count_reg <= value_i;
    end else if (en_i && !zero_o) begin
      count_reg <= count_reg - CntW'(1);
    end
  end

endmodule

// File: rtl/flash_phy_erase.sv
// Physical-side erase sequencer. Takes a held erase request (page or bank)
// from the controller's erase stage, validates it, holds the flash macro erase
// strobe for a fixed number of cycles and answers with a one-cycle done or
// error pulse. Every output is a register.
//
// Ports:
//   clk_i             in   clock
//   rst_ni            in   asynchronous active-low reset
//   req_i             in   erase request, level, held until done_o/err_o
//   op_i              in   EraseBitWidth  PageErase / BankErase
//   addr_i            in   AddrW          aligned erase address {bank, page, word}
//   bk_erase_en_i     in   bank erase permitted
//   done_o            out  1-cycle pulse: erase completed (suppressed if req_i dropped)
//   err_o             out  1-cycle pulse: request rejected
//   busy_o            out  high whenever the sequencer is not idle
//   mac_erase_o       out  macro erase strobe, high for the full erase duration
//   mac_bank_erase_o  out  macro erase type, 1 = bank erase
//   mac_page_o        out  {bank, page} index presented to the macro
module flash_phy_erase
  import flash_phy_pkg::*;
#(
  parameter int AddrW           = 17,
  parameter int WordsPerPage    = 256,
  parameter int PagesPerBank    = 256,
  parameter int Banks           = 2,
  parameter int EraseBitWidth   = 1,
  parameter int PageEraseCycles = 100,
  parameter int BankEraseCycles = 1000
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    req_i,
  input  logic [EraseBitWidth-1:0]                op_i,
  input  logic [AddrW-1:0]                        addr_i,
  input  logic                                    bk_erase_en_i,
  output logic                                    done_o,
  output logic                                    err_o,
  output logic                                    busy_o,
  output logic                                    mac_erase_o,
  output logic                                    mac_bank_erase_o,
  output logic [AddrW-$clog2(WordsPerPage)-1:0]   mac_page_o
);

  localparam int          WordsBitWidth = $clog2(WordsPerPage);
  localparam int          PagesBitWidth = $clog2(PagesPerBank);
  localparam int          PageIdxW      = AddrW - WordsBitWidth;
  localparam int unsigned NumPages      = Banks * PagesPerBank;
  localparam int          CntW          = erase_cnt_width(PageEraseCycles, BankEraseCycles);

  // The counter is loaded with (cycles - 1) because the load cycle itself is
  // the first cycle the strobe is high.
  localparam logic [CntW-1:0] PageLoad = CntW'(PageEraseCycles - 1);
  localparam logic [CntW-1:0] BankLoad = CntW'(BankEraseCycles - 1);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [PageIdxW-1:0] req_page;
  logic [PageIdxW-1:0] bank_mask;
  logic                req_is_bank;
  logic                req_is_page;
  logic                req_bad;
  logic                unused_word_bits;

  assign req_page = addr_i[AddrW-1:WordsBitWidth];

  // Word offset within a page plays no part in an erase.
  assign unused_word_bits = ^addr_i[WordsBitWidth-1:0];

  // A bank erase keeps only the bank bits of the page index.
  for (genvar gi = 0; gi < PageIdxW; gi++) begin : g_bank_mask
    assign bank_mask[gi] = (gi >= PagesBitWidth);
  end

  assign req_is_bank = (op_i == EraseBitWidth'(BankErase));
  assign req_is_page = (op_i == EraseBitWidth'(PageErase));

  // Reject bank erases that are not permitted, op codes that are neither page
  // nor bank (only reachable with a wider op field), and page indices beyond
  // the last implemented bank.
  assign req_bad = (req_is_bank && !bk_erase_en_i)
                || !(req_is_bank || req_is_page)
                || (32'(req_page) >= NumPages);

  // ---------------------------------------------------------------------------
  // Erase duration timer
  // ---------------------------------------------------------------------------
  logic            timer_load;
  logic [CntW-1:0] timer_value;
  logic            timer_en;
  logic            timer_zero;

  flash_phy_erase_timer #(
    .CntW (CntW)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (timer_load),
    .value_i (timer_value),
    .en_i    (timer_en),
    .zero_o  (timer_zero)
  );

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       accept;
  logic       done_next;
  logic       err_next;

  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    timer_load  = 1'b0;
    timer_value = '0;
    timer_en    = 1'b0;

    case (state_reg)
      StIdle: begin
        if (req_i) begin
          accept = 1'b1;
          if (req_bad) begin
            state_next = StErr;
            err_next   = 1'b1;
          end else begin
            state_next  = StErase;
            timer_load  = 1'b1;
            timer_value = req_is_bank ? BankLoad : PageLoad;
          end
        end
      end

      StErase: begin
        // The macro erase cannot be aborted, so req_i only decides whether the
        // completion is reported, not whether the erase finishes.
        if (timer_zero) begin
          state_next = StDone;
          done_next  = req_i;
        end else begin
          timer_en = 1'b1;
        end
      end

      StDone: state_next = StIdle;
      StErr:  state_next = StIdle;
      default: state_next = StIdle;
    endcase
  end

  // Outputs are registered from the next-state decode so that each pulse and
  // the strobe line up exactly with the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg        <= StIdle;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
      busy_o           <= 1'b0;
      mac_erase_o      <= 1'b0;
      mac_bank_erase_o <= 1'b0;
      mac_page_o       <= '0;
    end else begin
      state_reg   <= state_next;
      done_o      <= done_next;
      err_o       <= err_next;
      busy_o      <= (state_next != StIdle);
      mac_erase_o <= (state_next == StErase);
      // Op and page are captured only when a request is taken in IDLE, so they
      // stay stable for the whole erase regardless of what op_i/addr_i do.
      if (accept) begin
        mac_bank_erase_o <= req_is_bank;
        mac_page_o       <= req_is_bank ? (req_page & bank_mask) : req_page;
      end
    end
  end

endmodule

// File: tb/tb_flash_phy_erase.sv
module tb_flash_phy_erase;
  import flash_phy_pkg::*;

  localparam int PageCyc = 100;
  localparam int BankCyc = 1000;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Main instance (default parameters)
  logic        rst_ni;
  logic        req_i;
  logic [0:0]  op_i;
  logic [16:0] addr_i;
  logic        bk_erase_en_i;
  logic        done_o, err_o, busy_o, mac_erase_o, mac_bank_erase_o;
  logic [8:0]  mac_page_o;

  // Wide-address instance (AddrW = 18)
  logic        req_w;
  logic [0:0]  op_w;
  logic [17:0] addr_w;
  logic        bk_w;
  logic        done_w, err_w, busy_w, mac_erase_w, mac_bank_w;
  logic [9:0]  mac_page_w;

  flash_phy_erase dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_i            (req_i),
    .op_i             (op_i),
    .addr_i           (addr_i),
    .bk_erase_en_i    (bk_erase_en_i),
    .done_o           (done_o),
    .err_o            (err_o),
    .busy_o           (busy_o),
    .mac_erase_o      (mac_erase_o),
    .mac_bank_erase_o (mac_bank_erase_o),
    .mac_page_o       (mac_page_o)
  );

  flash_phy_erase #(.AddrW(18)) dut_w (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .req_i            (req_w),
    .op_i             (op_w),
    .addr_i           (addr_w),
    .bk_erase_en_i    (bk_w),
    .done_o           (done_w),
    .err_o            (err_w),
    .busy_o           (busy_w),
    .mac_erase_o      (mac_erase_w),
    .mac_bank_erase_o (mac_bank_w),
    .mac_page_o       (mac_page_w)
  );

  typedef struct {
    logic [1:0] kind;     // 2'b10 = done, 2'b01 = err
    int         exp_cyc;
    int         len;
    logic [8:0] page;
    logic       bank;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_total   = 0;
  int   n_bad     = 0;
  int   cyc       = 0;
  int   erase_run = 0;
  int   last_len  = 0;
  int   done_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Output monitor: measures strobe length and scores done/err pulses.
  initial begin
    forever begin
      @(negedge clk_i);
      if (mac_erase_o) begin
        erase_run++;
      end else if (erase_run > 0) begin
        last_len  = erase_run;
        erase_run = 0;
      end
      if (done_o) done_cnt++;
      if (done_o || err_o) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_pulse", {30'd0, done_o, err_o}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("pulse_kind", {30'd0, done_o, err_o}, {30'd0, mon_e.kind});
          check_eq("pulse_cycle", cyc, mon_e.exp_cyc);
          if (mon_e.kind == 2'b10) begin
            check_eq("erase_len", last_len, mon_e.len);
            check_eq("done_page", {23'd0, mac_page_o}, {23'd0, mon_e.page});
            check_eq("done_bank", {31'd0, mac_bank_erase_o}, {31'd0, mon_e.bank});
          end else begin
            check_eq("err_no_erase", {31'd0, mac_erase_o}, 32'd0);
          end
        end
      end
    end
  end

  // One request on the main instance. drop_at > 0 drops req_i that many
  // cycles into the erase and expects no done pulse.
  task automatic run_req(input string name, input logic op, input logic [16:0] addr,
                         input logic bken, input bit exp_err, input int drop_at);
    exp_t e;
    int   len;
    int   c0;
    int   dc0;
    len = (op == BankErase) ? BankCyc : PageCyc;
    @(negedge clk_i);
    e.kind    = exp_err ? 2'b01 : 2'b10;
    e.exp_cyc = cyc + 1 + (exp_err ? 0 : len);
    e.len     = len;
    e.page    = (op == BankErase) ? {addr[16], 8'h00} : addr[16:8];
    e.bank    = op;
    if (drop_at == 0) sb.push_back(e);
    dc0           = done_cnt;
    c0            = cyc;
    op_i          = op;
    addr_i        = addr;
    bk_erase_en_i = bken;
    req_i         = 1'b1;
    $display("req %s op=%0d addr=0x%05h bk_en=%0d expect=%s", name, op, addr, bken,
             exp_err ? "err" : (drop_at > 0 ? "silent" : "done"));
    @(negedge clk_i);
    check_eq({name, "_busy"}, {31'd0, busy_o}, 32'd1);
    check_eq({name, "_strobe"}, {31'd0, mac_erase_o}, exp_err ? 32'd0 : 32'd1);
    if (!exp_err) begin
      check_eq({name, "_page"}, {23'd0, mac_page_o}, {23'd0, e.page});
      check_eq({name, "_bank"}, {31'd0, mac_bank_erase_o}, {31'd0, e.bank});
    end
    // Disturb the inputs once the request is taken; they must be ignored.
    op_i   = ~op;
    addr_i = 17'($urandom);
    for (int k = 0; k < len + 20; k++) begin
      if (busy_o == 1'b0) break;
      if (drop_at > 0 && (cyc - c0) == drop_at) req_i = 1'b0;
      if (done_o || err_o) req_i = 1'b0;
      @(negedge clk_i);
    end
    check_eq({name, "_idle"}, {31'd0, busy_o}, 32'd0);
    req_i = 1'b0;
    if (drop_at > 0) begin
      check_eq({name, "_len"}, last_len, len);
      check_eq({name, "_no_done"}, done_cnt, dc0);
    end
  endtask

  initial begin
    int dc0;
    bit got;
    rst_ni        = 1'b0;
    req_i         = 1'b0;
    op_i          = PageErase;
    addr_i        = '0;
    bk_erase_en_i = 1'b0;
    req_w         = 1'b0;
    op_w          = PageErase;
    addr_w        = '0;
    bk_w          = 1'b0;

    repeat (3) @(negedge clk_i);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_err", {31'd0, err_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_strobe", {31'd0, mac_erase_o}, 32'd0);
    check_eq("rst_bank", {31'd0, mac_bank_erase_o}, 32'd0);
    check_eq("rst_page", {23'd0, mac_page_o}, 32'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    run_req("page_005",   PageErase, 17'h00500, 1'b0, 1'b0, 0);
    run_req("bank_1",     BankErase, 17'h10000, 1'b1, 1'b0, 0);
    run_req("bank_1_un",  BankErase, 17'h12345, 1'b1, 1'b0, 0);
    run_req("bank_dis",   BankErase, 17'h10000, 1'b0, 1'b1, 0);
    run_req("page_last",  PageErase, 17'h1FF00, 1'b0, 1'b0, 0);
    run_req("page_drop",  PageErase, 17'h00700, 1'b0, 1'b0, 50);
    run_req("page_after", PageErase, 17'h0AB00, 1'b0, 1'b0, 0);

    // Reset in the middle of an erase: strobe and busy drop at once, no done.
    @(negedge clk_i);
    dc0    = done_cnt;
    op_i   = PageErase;
    addr_i = 17'h00300;
    req_i  = 1'b1;
    $display("req rst_mid op=0 addr=0x00300 expect=reset");
    repeat (20) @(negedge clk_i);
    check_eq("rstmid_strobe_on", {31'd0, mac_erase_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("rstmid_strobe", {31'd0, mac_erase_o}, 32'd0);
    check_eq("rstmid_busy", {31'd0, busy_o}, 32'd0);
    req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (150) @(negedge clk_i);
    check_eq("rstmid_no_done", done_cnt, dc0);
    check_eq("rstmid_idle", {31'd0, busy_o}, 32'd0);

    // Wide-address instance: page index 0x200 is past the last bank.
    @(negedge clk_i);
    op_w   = PageErase;
    addr_w = 18'h20000;
    bk_w   = 1'b1;
    req_w  = 1'b1;
    $display("req w_page_200 op=0 addr=0x20000 expect=err");
    @(negedge clk_i);
    check_eq("w_err", {31'd0, err_w}, 32'd1);
    check_eq("w_err_strobe", {31'd0, mac_erase_w}, 32'd0);
    req_w = 1'b0;
    @(negedge clk_i);
    check_eq("w_err_once", {31'd0, err_w}, 32'd0);
    check_eq("w_err_idle", {31'd0, busy_w}, 32'd0);
    check_eq("w_err_strobe2", {31'd0, mac_erase_w}, 32'd0);

    // Wide-address instance: last valid page 0x1FF erases normally.
    @(negedge clk_i);
    addr_w = 18'h1FF00;
    req_w  = 1'b1;
    $display("req w_page_1ff op=0 addr=0x1ff00 expect=done");
    @(negedge clk_i);
    check_eq("w_strobe", {31'd0, mac_erase_w}, 32'd1);
    check_eq("w_page", {22'd0, mac_page_w}, 32'h1FF);
    got = 1'b0;
    for (int k = 0; k < PageCyc + 20; k++) begin
      @(negedge clk_i);
      if (done_w) begin
        got = 1'b1;
        req_w = 1'b0;
        break;
      end
    end
    check_eq("w_done", {31'd0, got}, 32'd1);
    req_w = 1'b0;
    repeat (3) @(negedge clk_i);

    check_eq("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
